// File: rtl/io_input_cond_if.sv
// Board-input bundle: raw switch/button pins in, conditioned CPU-facing values out.
// Latency: none, declarations only.
// Backpressure: none; outputs are levels or single-cycle pulses with no handshake.
//
// Signals:
//   sw_in[23:0]   raw board switches, asynchronous and bouncing
//   btn_in        raw start button, asynchronous and bouncing
//   io_rdata[23:0] conditioned switch value (CPU io_rdata)
//   io_changed    one-cycle pulse when io_rdata takes a new value
//   start_uart    one-cycle pulse per accepted button press (CPU start_uart)
// The master modport drives the raw pins; the slave modport is the conditioner.
interface io_input_cond_if;
    logic [23:0] sw_in;
    logic        btn_in;
    logic [23:0] io_rdata;
    logic        io_changed;
    logic        start_uart;

    modport master (
        output sw_in,
        output btn_in,
        input  io_rdata,
        input  io_changed,
        input  start_uart
    );

    modport slave (
        input  sw_in,
        input  btn_in,
        output io_rdata,
        output io_changed,
        output start_uart
    );
endinterface

// File: rtl/io_input_cond.sv
// Synchronises and debounces the 24 board switches and the start button.
// Latency: DEBOUNCE_CYCLES+3 edges from a clean input step to io_rdata (3 edges without debounce).
// Backpressure: none; io_changed/start_uart are fire-and-forget single-cycle pulses.
//
// Ports:
//   clk       system clock, single domain, rising edge
//   fpga_rst  synchronous active-high reset
//   io        io_input_cond_if.slave: sw_in/btn_in in, io_rdata/io_changed/start_uart out
// Build option: define IO_INPUT_DEBOUNCE_EN to build the debounce counters; when it is
// undefined the synchronised inputs are passed straight through and DEBOUNCE_CYCLES is ignored.
// DEBOUNCE_CYCLES legal range is 2 .. 2**24.
module io_input_cond #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic           clk,
    input  logic           fpga_rst,
    io_input_cond_if.slave io
);

    // Two-flop synchronisers for the asynchronous board pins.
    logic [23:0] s1_sw_q;
    logic [23:0] s2_sw_q;
    logic        s1_btn_q;
    logic        s2_btn_q;

    // Conditioned outputs plus the one-cycle-old copies used for edge/change detection.
    logic [23:0] io_rdata_q;
    logic [23:0] io_rdata_d;
    logic [23:0] prev_rdata_q;
    logic        io_changed_q;
    logic        btn_db_q;
    logic        btn_db_d;
    logic        btn_prev_q;
    logic        start_uart_q;

`ifdef IO_INPUT_DEBOUNCE_EN
    // Narrowest counter that still holds DEBOUNCE_CYCLES-1.
    localparam int                CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [23:0]      cand_sw_q;
    logic [23:0]      cand_sw_d;
    logic [CNT_W-1:0] cnt_sw_q;
    logic [CNT_W-1:0] cnt_sw_d;
    logic             cand_btn_q;
    logic             cand_btn_d;
    logic [CNT_W-1:0] cnt_btn_q;
    logic [CNT_W-1:0] cnt_btn_d;

    // Switch path: any change of the synchronised value restarts the stability count.
    // Once the count saturates the candidate is reloaded every edge; reloading an
    // unchanged value is harmless because io_changed compares against the old value.
    always_comb begin
        cand_sw_d  = cand_sw_q;
        cnt_sw_d   = cnt_sw_q;
        io_rdata_d = io_rdata_q;
        if (s2_sw_q != cand_sw_q) begin
            cand_sw_d = s2_sw_q;
            cnt_sw_d  = '0;
        end else if (cnt_sw_q == CNT_MAX) begin
            io_rdata_d = cand_sw_q;
        end else begin
            cnt_sw_d = cnt_sw_q + CNT_W'(1);
        end
    end

    // Button path: identical structure, fully separate state.
    always_comb begin
        cand_btn_d = cand_btn_q;
        cnt_btn_d  = cnt_btn_q;
        btn_db_d   = btn_db_q;
        if (s2_btn_q != cand_btn_q) begin
            cand_btn_d = s2_btn_q;
            cnt_btn_d  = '0;
        end else if (cnt_btn_q == CNT_MAX) begin
            btn_db_d = cand_btn_q;
        end else begin
            cnt_btn_d = cnt_btn_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fpga_rst) begin
            cand_sw_q  <= '0;
            cnt_sw_q   <= '0;
            cand_btn_q <= 1'b0;
            cnt_btn_q  <= '0;
        end else begin
            cand_sw_q  <= cand_sw_d;
            cnt_sw_q   <= cnt_sw_d;
            cand_btn_q <= cand_btn_d;
            cnt_btn_q  <= cnt_btn_d;
        end
    end
`else
    // Pass-through build: the parameter has no effect here.
    logic unused_cfg;
    assign unused_cfg = (DEBOUNCE_CYCLES > 0);

    always_comb begin
        io_rdata_d = s2_sw_q;
        btn_db_d   = s2_btn_q;
    end
`endif

    // Synchronisers, conditioned values and pulse generation. The previous-value
    // registers are cleared with everything else so reset release never pulses.
    always_ff @(posedge clk) begin
        if (fpga_rst) begin
            s1_sw_q      <= '0;
            s2_sw_q      <= '0;
            s1_btn_q     <= 1'b0;
            s2_btn_q     <= 1'b0;
            io_rdata_q   <= '0;
            prev_rdata_q <= '0;
            io_changed_q <= 1'b0;
            btn_db_q     <= 1'b0;
            btn_prev_q   <= 1'b0;
            start_uart_q <= 1'b0;
        end else begin
            s1_sw_q      <= io.sw_in;
            s2_sw_q      <= s1_sw_q;
            s1_btn_q     <= io.btn_in;
            s2_btn_q     <= s1_btn_q;
            io_rdata_q   <= io_rdata_d;
            // Pulse lands one edge after io_rdata takes a different value.
            prev_rdata_q <= io_rdata_q;
            io_changed_q <= (io_rdata_q != prev_rdata_q);
            btn_db_q     <= btn_db_d;
            // Rising edge of the debounced button only; release gives nothing.
            btn_prev_q   <= btn_db_q;
            start_uart_q <= btn_db_q & ~btn_prev_q;
        end
    end

    assign io.io_rdata   = io_rdata_q;
    assign io.io_changed = io_changed_q;
    assign io.start_uart = start_uart_q;

endmodule

// File: tb/tb_io_input_cond.sv
// Bench for io_input_cond: directed scenarios plus randomised traffic against a
// window-based reference model (a value is accepted once the synchronised input has
// held it for DEBOUNCE_CYCLES+1 consecutive edges).
module tb_io_input_cond;
`ifdef IO_INPUT_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    localparam int          N    = 4;
    localparam int          W    = DB_EN ? N : 0;
    localparam int          LAT  = W + 3;
    localparam int          HMAX = 4096;
    localparam logic [24:0] SENT = 25'h1000000;

    logic clk = 1'b0;
    logic fpga_rst;

    io_input_cond_if bus();

    io_input_cond #(.DEBOUNCE_CYCLES(N)) dut (
        .clk      (clk),
        .fpga_rst (fpga_rst),
        .io       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Input history indexed by edge number; SENT marks "no stable history before here".
    logic [24:0] xh [HMAX];
    logic [24:0] bh [HMAX];
    int          cyc;
    logic [23:0] m_rd;
    logic [23:0] m_prev;
    logic        m_chg;
    logic        m_db;
    logic        m_dbprev;
    logic        m_start;

    function automatic bit sw_stable(input int idx);
        bit ok;
        ok = (xh[idx][24] == 1'b0);
        for (int j = 1; j <= W; j++)
            if (xh[idx-j] != xh[idx]) ok = 1'b0;
        return ok;
    endfunction

    function automatic bit btn_stable(input int idx);
        bit ok;
        ok = (bh[idx][24] == 1'b0);
        for (int j = 1; j <= W; j++)
            if (bh[idx-j] != bh[idx]) ok = 1'b0;
        return ok;
    endfunction

    task automatic model_step(input logic r, input logic [23:0] sw, input logic b);
        cyc++;
        if (r) begin
            for (int k = 0; k < 3; k++) begin
                xh[cyc-k] = '0;
                bh[cyc-k] = '0;
            end
            xh[cyc-3] = SENT;
            bh[cyc-3] = SENT;
            m_rd = '0; m_prev = '0; m_chg = 1'b0;
            m_db = 1'b0; m_dbprev = 1'b0; m_start = 1'b0;
        end else begin
            xh[cyc]  = {1'b0, sw};
            bh[cyc]  = {24'b0, b};
            m_chg    = (m_rd != m_prev);
            m_start  = m_db && !m_dbprev;
            m_prev   = m_rd;
            m_dbprev = m_db;
            if (sw_stable(cyc-2)) m_rd = xh[cyc-2][23:0];
            if (btn_stable(cyc-2)) m_db = bh[cyc-2][0];
        end
    endtask

    task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h, expected %h", nm, cyc, got, want);
        end
    endtask

    task automatic tick(input logic r, input logic [23:0] sw, input logic b);
        fpga_rst   = r;
        bus.sw_in  = sw;
        bus.btn_in = b;
        @(posedge clk);
        model_step(r, sw, b);
        #1;
        chk("model_rdata",   bus.io_rdata, m_rd);
        chk("model_changed", {23'b0, bus.io_changed}, {23'b0, m_chg});
        chk("model_start",   {23'b0, bus.start_uart}, {23'b0, m_start});
    endtask

    typedef struct {
        string       name;
        logic [23:0] sw;
        logic        btn;
        int          cycles;
        logic [23:0] exp_rdata;
        int          exp_chg;
        int          exp_start;
    } vec_t;

    initial begin
        vec_t        vt [4];
        int          pulses;
        int          last_pulse;
        int          len;
        logic        bad;
        logic        rnd_rst;
        logic [23:0] sw_now;
        logic        btn_now;

        for (int i = 0; i < HMAX; i++) begin
            xh[i] = SENT;
            bh[i] = SENT;
        end
        cyc = 8;
        m_rd = '0; m_prev = '0; m_chg = 1'b0;
        m_db = 1'b0; m_dbprev = 1'b0; m_start = 1'b0;
        fpga_rst = 1'b1; bus.sw_in = '0; bus.btn_in = 1'b0;

        // Reset held for 5 edges with switches set: everything stays 0.
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 24'hFFFF01, 1'b0);
            chk("rst_rdata",   bus.io_rdata, 24'h0);
            chk("rst_changed", {23'b0, bus.io_changed}, 24'h0);
            chk("rst_start",   {23'b0, bus.start_uart}, 24'h0);
        end

        // Clean step after reset: accepted at edge LAT, io_changed at LAT+1 only.
        for (int i = 1; i <= LAT + 2; i++) begin
            tick(1'b0, 24'hFFFF01, 1'b0);
            chk("step_rdata",   bus.io_rdata, (i >= LAT) ? 24'hFFFF01 : 24'h0);
            chk("step_changed", {23'b0, bus.io_changed}, (i == LAT + 1) ? 24'd1 : 24'd0);
        end

        // Two-cycle glitch to FFFF09 then back.
        pulses = 0; bad = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick(1'b0, (i <= 2) ? 24'hFFFF09 : 24'hFFFF01, 1'b0);
            if (bus.io_changed) pulses++;
            if (bus.io_rdata != 24'hFFFF01) bad = 1'b1;
        end
        chk("glitch_pulses",  24'(pulses), 24'(DB_EN ? 0 : 2));
        chk("glitch_visible", {23'b0, bad}, {23'b0, !DB_EN});
        chk("glitch_final",   bus.io_rdata, 24'hFFFF01);

        // Button bounce 0-1-0-1 then hold 20: final rise is sampled at i=4.
        pulses = 0; last_pulse = -1;
        for (int i = 1; i <= 23; i++) begin
            tick(1'b0, 24'hFFFF01, (i == 2) || (i >= 4));
            if (bus.start_uart) begin
                pulses++;
                last_pulse = i - 3;
            end
        end
        chk("btn_pulses",     24'(pulses), 24'(DB_EN ? 1 : 2));
        chk("btn_pulse_edge", 24'(last_pulse), 24'(LAT + 1));

        // Release gives no pulse.
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 24'hFFFF01, 1'b0);
            if (bus.start_uart) pulses++;
        end
        chk("btn_release", 24'(pulses), 24'h0);

        // Step to FFFF09, reset at edge 5 for one cycle, then full latency again.
        for (int i = 1; i <= 4; i++) tick(1'b0, 24'hFFFF09, 1'b0);
        tick(1'b1, 24'hFFFF09, 1'b0);
        chk("midrst_rdata",   bus.io_rdata, 24'h0);
        chk("midrst_changed", {23'b0, bus.io_changed}, 24'h0);
        for (int j = 1; j <= LAT + 2; j++) begin
            tick(1'b0, 24'hFFFF09, 1'b0);
            chk("post_rst_rdata",   bus.io_rdata, (j >= LAT) ? 24'hFFFF09 : 24'h0);
            chk("post_rst_changed", {23'b0, bus.io_changed}, (j == LAT + 1) ? 24'd1 : 24'd0);
        end

        // Table rows: long holds that settle identically in both builds; switch and
        // button move together to show the paths do not interact.
        vt[0] = '{"tbl_sw_a",  24'h123456, 1'b0, LAT + 4, 24'h123456, 1, 0};
        vt[1] = '{"tbl_both",  24'hABCDEF, 1'b1, LAT + 4, 24'hABCDEF, 1, 1};
        vt[2] = '{"tbl_same",  24'hABCDEF, 1'b1, LAT + 4, 24'hABCDEF, 0, 0};
        vt[3] = '{"tbl_zero",  24'h000000, 1'b0, LAT + 4, 24'h000000, 1, 0};
        for (int r = 0; r < 4; r++) begin
            int chg_n;
            int st_n;
            chg_n = 0; st_n = 0;
            for (int k = 0; k < vt[r].cycles; k++) begin
                tick(1'b0, vt[r].sw, vt[r].btn);
                if (bus.io_changed) chg_n++;
                if (bus.start_uart) st_n++;
            end
            chk({vt[r].name, "_rdata"}, bus.io_rdata, vt[r].exp_rdata);
            chk({vt[r].name, "_chg"},   24'(chg_n), 24'(vt[r].exp_chg));
            chk({vt[r].name, "_start"}, 24'(st_n), 24'(vt[r].exp_start));
        end

        // Randomised traffic with occasional resets, checked every edge by the model.
        sw_now = 24'h0; btn_now = 1'b0;
        for (int s = 0; s < 300; s++) begin
            if (cyc >= HMAX - 20) break;
            len = $urandom_range(1, 8);
            case ($urandom_range(0, 3))
                0:       sw_now = 24'($urandom);
                1:       sw_now[$urandom_range(0, 23)] = ~sw_now[$urandom_range(0, 23)];
                2:       btn_now = ~btn_now;
                default: begin sw_now = sw_now ^ 24'h000001; btn_now = ~btn_now; end
            endcase
            rnd_rst = ($urandom_range(0, 29) == 0);
            for (int k = 0; k < len; k++) tick(rnd_rst && (k == 0), sw_now, btn_now);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
